// File: rtl/shift_seq.sv
// shift_seq: command sequencer for an external 8-bit shift register.
// A command can parallel-load the shifter, then run it for 0..15 cycles
// in a chosen direction. It then captures the shifter contents into result
// and pulses done. Every output is a register that is written from the
// next state. Each output therefore always matches a Moore decode of the
// current state.
module shift_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [7:0] cmd_data,
  input  logic [2:0] cmd_dir,
  input  logic [3:0] cmd_count,
  input  logic       abort,
  output logic       sr_enable,
  output logic [2:0] sr_dir,
  output logic [7:0] sr_data,
  input  logic [7:0] sr_q,
  output logic [7:0] result,
  output logic       done,
  output logic       busy,
  output logic [7:0] done_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [2:0] DIR_LOAD = 3'b011;

  state_t     state_q, state_d;
  logic       load_q, load_d;
  logic [7:0] data_q, data_d;
  logic [2:0] dir_q, dir_d;
  logic [3:0] rem_q, rem_d;

  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       sr_enable_q, sr_enable_d;
  logic [2:0] sr_dir_q, sr_dir_d;
  logic [7:0] sr_data_q, sr_data_d;
  logic [7:0] result_q, result_d;
  logic       done_q, done_d;
  logic [7:0] done_count_q, done_count_d;

  logic       accept_s;

  // cmd_ready is high only in IDLE, so acceptance is a plain handshake
  assign accept_s = cmd_valid & ready_q;

  // State and command-latch registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      load_q  <= 1'b0;
      data_q  <= 8'h00;
      dir_q   <= 3'b000;
      rem_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic, command latching and remaining-shift countdown
  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    data_d  = data_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          load_d = cmd_load;
          data_d = cmd_data;
          dir_d  = cmd_dir;
          rem_d  = cmd_count;
          if (cmd_load) begin
            state_d = LOAD;
          end else if (cmd_count != 4'h0) begin
            state_d = SHIFT;
          end else begin
            state_d = SETTLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (rem_q != 4'h0) begin
          state_d = SHIFT;
        end else begin
          state_d = SETTLE;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_q - 4'h1;
          if (rem_q == 4'h1) begin
            state_d = SETTLE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        // abort is ignored here: the command has already finished
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state; sr_dir/sr_data hold while disabled
  always_comb begin
    sr_enable_d  = 1'b0;
    sr_dir_d     = sr_dir_q;
    sr_data_d    = sr_data_q;
    ready_d      = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
    result_d     = result_q;
    done_count_d = done_count_q;
    case (state_d)
      LOAD: begin
        sr_enable_d = 1'b1;
        sr_dir_d    = DIR_LOAD;
        sr_data_d   = data_d;
      end
      SHIFT: begin
        sr_enable_d = 1'b1;
        sr_dir_d    = dir_d;
        sr_data_d   = data_d;
      end
      default: begin
        sr_enable_d = 1'b0;
      end
    endcase
    // Capture only on a completed SETTLE; an aborted one leaves result alone
    if ((state_q == SETTLE) && (state_d == DONE)) begin
      result_d = sr_q;
    end else begin
      result_d = result_q;
    end
    // Count the completion as DONE is left; wraps naturally at 8 bits
    if (state_q == DONE) begin
      done_count_d = done_count_q + 8'h01;
    end else begin
      done_count_d = done_count_q;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      sr_enable_q  <= 1'b0;
      sr_dir_q     <= 3'b000;
      sr_data_q    <= 8'h00;
      result_q     <= 8'h00;
      done_q       <= 1'b0;
      done_count_q <= 8'h00;
    end else begin
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      sr_enable_q  <= sr_enable_d;
      sr_dir_q     <= sr_dir_d;
      sr_data_q    <= sr_data_d;
      result_q     <= result_d;
      done_q       <= done_d;
      done_count_q <= done_count_d;
    end
  end

  assign cmd_ready  = ready_q;
  assign busy       = busy_q;
  assign sr_enable  = sr_enable_q;
  assign sr_dir     = sr_dir_q;
  assign sr_data    = sr_data_q;
  assign result     = result_q;
  assign done       = done_q;
  assign done_count = done_count_q;

endmodule
